mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy cycles for MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10, busy cycles for DIV/DIVU.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 SrcA  input  32  E-stage rs operand, same forwarded value fed to the ALU.
REQ-006 SrcB  input  32  E-stage rt operand, same forwarded value fed to the ALU.
REQ-007 MDUCtrl  input  4  op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 treated as NONE.
REQ-008 req  input  1  exception/interrupt flush of the E-stage instruction this cycle.
REQ-009 mdStart  output  1  combinational; starting a mult/div this cycle.
REQ-010 busy  output  1  registered; mult/div in progress.
REQ-011 HI  output  32  architectural HI register.
REQ-012 LO  output  32  architectural LO register.
REQ-013 MDUOut  output  32  combinational: HI if op MFHI, LO if op MFLO, else 0.

Function
REQ-014 mdStart SHALL be 1 iff MDUCtrl in {1..4} and busy==0 and req==0.
REQ-015 On an edge with mdStart==1: SrcA, SrcB and op SHALL be latched; counter loaded with MULT_CYCLES or DIV_CYCLES; busy=1 from next cycle.
REQ-016 States: IDLE (busy=0) and RUN (busy=1); IDLE->RUN on mdStart; RUN->IDLE on the edge where counter reaches 1, at which edge HI/LO are written.
REQ-017 Result visible on HI/LO exactly N cycles after the start edge (N = MULT_CYCLES or DIV_CYCLES); busy high for exactly N cycles.
REQ-018 MULT: {HI,LO} = signed 64-bit product; MULTU: unsigned 64-bit product.
REQ-019 DIV: LO = signed quotient truncated toward zero, HI = remainder with sign of dividend; DIVU: unsigned quotient/remainder.
REQ-020 DIV/DIVU with latched divisor 0 SHALL run full DIV_CYCLES and leave HI and LO unchanged.
REQ-021 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0; no exception raised.
REQ-022 Results SHALL use only latched operands; SrcA/SrcB changes during RUN have no effect.
REQ-023 MTHI/MTLO SHALL write SrcA to HI/LO at the edge, only when busy==0 and req==0.
REQ-024 Any op (1-8) presented while busy==1 SHALL be ignored; stall control holds it upstream.
REQ-025 req==1 SHALL suppress a start or MTHI/MTLO that cycle but SHALL NOT abort a RUN in progress.
REQ-026 MFHI/MFLO during RUN SHALL return current (old) HI/LO; stall control prevents this.
REQ-027 Stall control SHALL stall any D-stage op 1-8 while (mdStart || busy).
REQ-028 MDU SHALL raise no exception code; overflow and address checks remain in the ALU.

Reset
REQ-029 reset==1 SHALL immediately force HI=0, LO=0, busy=0, counter=0, state IDLE, regardless of clock.
REQ-030 reset during RUN SHALL discard the operation; no HI/LO write after release.
REQ-031 First start accepted on the first rising edge with reset==0.

Verification
REQ-032 MULTU SrcA=0xFFFFFFFF SrcB=2 -> busy 5 cycles, then HI=0x00000001, LO=0xFFFFFFFE.
REQ-033 DIV SrcA=0xFFFFFFF9 (-7) SrcB=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-034 MTHI 0x1234, MTLO 0x5678, then DIVU by 0 -> busy 10 cycles, HI=0x1234, LO=0x5678 unchanged.
REQ-035 MULT with req=1 same cycle -> mdStart=0, busy stays 0, HI/LO unchanged; MTLO with req=1 -> LO unchanged.
REQ-036 MULT started, reset pulsed at cycle 3 -> HI=LO=0 and busy=0 at once and no later write.
REQ-037 MULT started, MTLO and new DIV presented during RUN -> both ignored; only MULT result written.

Source files
------------

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO pair.
// An op is latched at start, runs a fixed number of cycles, then writes HI/LO once.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic [3:0]  MDUCtrl,
    input  logic        req,
    output logic        mdStart,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOut
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, b_safe, qmag, rmag, quo_s, rem_s, quo_u, rem_u;

    assign busy    = (state_q == RUN);
    assign HI      = hi_q;
    assign LO      = lo_q;
    assign mdStart = (MDUCtrl >= OP_MULT) && (MDUCtrl <= OP_DIVU) && !busy && !req;

    // Arithmetic sees only the latched operands, never the live forwarded inputs.
    always_comb begin
        prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u = {32'b0, a_q} * {32'b0, b_q};
        // Divisor forced nonzero so the divider never sees 0; the write is skipped anyway.
        b_safe = (b_q == 32'd0) ? 32'd1 : b_q;
        abs_a  = a_q[31] ? (32'd0 - a_q) : a_q;
        abs_b  = b_safe[31] ? (32'd0 - b_safe) : b_safe;
        // Magnitude division sidesteps the MIN/-1 overflow; the negate wraps to 0x80000000.
        qmag   = abs_a / abs_b;
        rmag   = abs_a % abs_b;
        quo_s  = (a_q[31] ^ b_safe[31]) ? (32'd0 - qmag) : qmag;
        rem_s  = a_q[31] ? (32'd0 - rmag) : rmag;
        quo_u  = a_q / b_safe;
        rem_u  = a_q % b_safe;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (mdStart) begin
                    a_d     = SrcA;
                    b_d     = SrcB;
                    op_d    = MDUCtrl;
                    cnt_d   = (MDUCtrl == OP_MULT || MDUCtrl == OP_MULTU) ?
                              16'(MULT_CYCLES) : 16'(DIV_CYCLES);
                    state_d = RUN;
                end else if (!req && MDUCtrl == OP_MTHI) begin
                    hi_d = SrcA;
                end else if (!req && MDUCtrl == OP_MTLO) begin
                    lo_d = SrcA;
                end
            end
            RUN: begin
                if (cnt_q <= 16'd1) begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                    case (op_q)
                        OP_MULT:  {hi_d, lo_d} = prod_s;
                        OP_MULTU: {hi_d, lo_d} = prod_u;
                        OP_DIV:   if (b_q != 32'd0) begin hi_d = rem_s; lo_d = quo_s; end
                        OP_DIVU:  if (b_q != 32'd0) begin hi_d = rem_u; lo_d = quo_u; end
                        default:  ;
                    endcase
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Reads return the current HI/LO even mid-run; the pipeline stalls such reads.
    always_comb begin
        MDUOut = 32'd0;
        if (MDUCtrl == OP_MFHI) MDUOut = hi_q;
        else if (MDUCtrl == OP_MFLO) MDUOut = lo_q;
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: vector table through a result scoreboard,
// plus directed sequences for divide-by-zero, flush, reset and busy corners.
module tb_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] SrcA, SrcB;
    logic [3:0]  MDUCtrl;
    logic        req;
    logic        mdStart, busy;
    logic [31:0] HI, LO, MDUOut;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    vec_t vecs[11];
    exp_t sb[$];

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .SrcA(SrcA), .SrcB(SrcB), .MDUCtrl(MDUCtrl),
        .req(req), .mdStart(mdStart), .busy(busy), .HI(HI), .LO(LO), .MDUOut(MDUOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start an op, scramble the live operands during the run, and check the
    // busy length and the popped scoreboard entry once busy drops.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        int   cnt;
        e.hi = ehi;
        e.lo = elo;
        e.cycles = (op <= 4'd2) ? 5 : 10;
        MDUCtrl = op; SrcA = a; SrcB = b;
        #1;
        chk({name, " mdStart"}, 32'(mdStart), 32'd1);
        sb.push_back(e);
        tick();
        MDUCtrl = 4'd0; SrcA = $urandom; SrcB = $urandom;
        cnt = 0;
        while (busy && cnt < 60) begin
            cnt++;
            tick();
        end
        e = sb.pop_front();
        chk({name, " busy cycles"}, 32'(cnt), 32'(e.cycles));
        chk({name, " HI"}, HI, e.hi);
        chk({name, " LO"}, LO, e.lo);
    endtask

    initial begin
        vecs[0]  = '{4'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
        vecs[1]  = '{4'd1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[2]  = '{4'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[3]  = '{4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[4]  = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[5]  = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[6]  = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7]  = '{4'd4, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC};
        vecs[8]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[9]  = '{4'd4, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        vecs[10] = '{4'd3, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E};

        reset = 1'b1; req = 1'b0; MDUCtrl = 4'd0; SrcA = 32'd0; SrcB = 32'd0;
        tick();
        tick();
        chk("reset HI", HI, 32'd0);
        chk("reset LO", LO, 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // First start lands on the very first edge after reset release.
        for (int i = 0; i < 11; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

        // MTHI/MTLO then divide by zero leaves HI/LO alone.
        MDUCtrl = 4'd7; SrcA = 32'h1234; tick();
        MDUCtrl = 4'd8; SrcA = 32'h5678; tick();
        MDUCtrl = 4'd5; #1;
        chk("MFHI", MDUOut, 32'h1234);
        MDUCtrl = 4'd6; #1;
        chk("MFLO", MDUOut, 32'h5678);
        MDUCtrl = 4'd12; #1;
        chk("op12 MDUOut", MDUOut, 32'd0);
        chk("op12 mdStart", 32'(mdStart), 32'd0);
        run_op("divu0", 4'd4, 32'd77, 32'd0, 32'h1234, 32'h5678);

        // Flush suppresses start and MTLO.
        req = 1'b1; MDUCtrl = 4'd1; SrcA = 32'd3; SrcB = 32'd3; #1;
        chk("req mdStart", 32'(mdStart), 32'd0);
        tick();
        chk("req busy", 32'(busy), 32'd0);
        chk("req HI", HI, 32'h1234);
        MDUCtrl = 4'd8; SrcA = 32'hDEAD; tick();
        chk("req MTLO", LO, 32'h5678);
        req = 1'b0; MDUCtrl = 4'd0;

        // Ops presented during a run are ignored.
        MDUCtrl = 4'd2; SrcA = 32'd3; SrcB = 32'd5; tick();
        MDUCtrl = 4'd8; SrcA = 32'hDEAD; tick();
        MDUCtrl = 4'd3; SrcA = 32'd9; SrcB = 32'd2; #1;
        chk("busy mdStart", 32'(mdStart), 32'd0);
        tick();
        chk("busy MTLO ignored", LO, 32'h5678);
        MDUCtrl = 4'd0;
        for (int i = 0; i < 5; i++) tick();
        chk("busy-ignore busy", 32'(busy), 32'd0);
        chk("busy-ignore HI", HI, 32'd0);
        chk("busy-ignore LO", LO, 32'd15);

        // Reset mid-run clears at once and discards the result.
        MDUCtrl = 4'd1; SrcA = 32'd6; SrcB = 32'd7; tick();
        MDUCtrl = 4'd0;
        tick(); tick();
        reset = 1'b1; #1;
        chk("async reset HI", HI, 32'd0);
        chk("async reset LO", LO, 32'd0);
        chk("async reset busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("post-reset busy", 32'(busy), 32'd0);
        chk("post-reset LO", LO, 32'd0);
        chk("post-reset HI", HI, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
